// File: rtl/ultrasonic_measd_if.sv
// Pin and result bundle between the range finder,
// the sensor pins and the consumer logic.
interface ultrasonic_measd_if;
  logic       trigger;
  logic       triggerEn;
  logic       sTrigger;
  logic       sEcho;
  logic [7:0] meas;
  logic       measReady;

  modport master (
    output trigger,
    output triggerEn,
    output sEcho,
    input  sTrigger,
    input  meas,
    input  measReady
  );

  modport slave (
    input  trigger,
    input  triggerEn,
    input  sEcho,
    output sTrigger,
    output meas,
    output measReady
  );
endinterface

// File: rtl/ultrasonic_measd.sv
// HC-SR04 style range finder: trigger pulse out,
// echo width timed and converted to cm.
module ultrasonic_measd #(
  parameter int TRIG_CYCLES  = 2,
  parameter int TICKS_PER_CM = 6,
  parameter int ECHO_TIMEOUT = 3800
) (
  input logic clock,
  input logic reset,
  ultrasonic_measd_if.slave bus
);

  localparam int TCW = (TRIG_CYCLES > 1)
                     ? $clog2(TRIG_CYCLES) : 1;
  localparam int PW  = (TICKS_PER_CM > 1)
                     ? $clog2(TICKS_PER_CM) : 1;
  localparam int TOW = (ECHO_TIMEOUT > 1)
                     ? $clog2(ECHO_TIMEOUT) : 1;

  localparam logic [TCW-1:0] T_LAST = TCW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0]  P_LAST = PW'(TICKS_PER_CM - 1);
  localparam logic [TOW-1:0] O_LAST = TOW'(ECHO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_ECHO, MEASURE, DONE
  } state_t;

  state_t         state;
  logic           echo_q;
  logic           echo_s;
  logic [TCW-1:0] trig_cnt;
  logic [TOW-1:0] to_cnt;
  logic [PW-1:0]  presc;
  logic [7:0]     cm_cnt;
  logic [PW-1:0]  presc_nxt;
  logic [7:0]     cm_nxt;

  // One echo-high clock: prescaler step, cm count saturating at 255
  always_comb begin
    presc_nxt = presc + PW'(1);
    cm_nxt    = cm_cnt;
    if (presc == P_LAST) begin
      presc_nxt = '0;
      if (cm_cnt != 8'hFF)
        cm_nxt = cm_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      echo_q        <= 1'b0;
      echo_s        <= 1'b0;
      trig_cnt      <= '0;
      to_cnt        <= '0;
      presc         <= '0;
      cm_cnt        <= '0;
      bus.sTrigger  <= 1'b0;
      bus.meas      <= '0;
      bus.measReady <= 1'b0;
    end else begin
      echo_q <= bus.sEcho;
      echo_s <= echo_q;
      case (state)
        IDLE: begin
          bus.measReady <= 1'b0;
          if (bus.trigger && bus.triggerEn) begin
            state        <= TRIG;
            bus.sTrigger <= 1'b1;
            trig_cnt     <= '0;
            to_cnt       <= '0;
            presc        <= '0;
            cm_cnt       <= '0;
          end
        end
        TRIG: begin
          trig_cnt <= trig_cnt + TCW'(1);
          if (trig_cnt == T_LAST) begin
            bus.sTrigger <= 1'b0;
            to_cnt       <= '0;
            state        <= WAIT_ECHO;
          end
        end
        WAIT_ECHO: begin
          // The clock that sees the rising edge is already echo time
          if (echo_s) begin
            presc  <= presc_nxt;
            cm_cnt <= cm_nxt;
            to_cnt <= '0;
            state  <= MEASURE;
          end else if (to_cnt == O_LAST) begin
            bus.meas      <= 8'hFF;
            bus.measReady <= 1'b1;
            state         <= DONE;
          end else begin
            to_cnt <= to_cnt + TOW'(1);
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            bus.meas      <= cm_cnt;
            bus.measReady <= 1'b1;
            state         <= DONE;
          end else if (to_cnt == O_LAST) begin
            bus.meas      <= 8'hFF;
            bus.measReady <= 1'b1;
            state         <= DONE;
          end else begin
            presc  <= presc_nxt;
            cm_cnt <= cm_nxt;
            to_cnt <= to_cnt + TOW'(1);
          end
        end
        DONE: begin
          bus.measReady <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_measd.sv
// Randomised bench for ultrasonic_measd against
// a width-to-cm reference model.
module tb_ultrasonic_measd;

  localparam int TICKS   = 6;
  localparam int TIMEOUT = 3800;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ultrasonic_measd_if bus ();

  ultrasonic_measd dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int trig_hi = 0;
  int rdy_cnt = 0;
  int last_meas = -1;

  always @(posedge clock) begin
    #1;
    if (bus.sTrigger === 1'b1) trig_hi++;
    if (bus.measReady === 1'b1) begin
      rdy_cnt++;
      last_meas = int'(bus.meas);
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp, input int tol = 0);
    n_tests++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (+-%0d)",
               tag, got, exp, tol);
    end
  endtask

  // Distance from echo width in clocks; 0 = no echo at all
  function automatic int model_meas(input int w);
    int q;
    if (w == 0 || w >= TIMEOUT) return 255;
    q = w / TICKS;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic clr_mon();
    trig_hi   = 0;
    rdy_cnt   = 0;
    last_meas = -1;
  endtask

  task automatic pulse_trigger(input logic en);
    @(negedge clock);
    bus.trigger   = 1'b1;
    bus.triggerEn = en;
    @(negedge clock);
    bus.trigger   = 1'b0;
  endtask

  task automatic run_meas(input string tag, input int delay,
                          input int width, input int tol,
                          input bit poke);
    int exp;
    exp = model_meas(width);
    clr_mon();
    pulse_trigger(1'b1);
    repeat (delay) @(negedge clock);
    if (width > 0) begin
      bus.sEcho = 1'b1;
      for (int i = 0; i < width; i++) begin
        if (poke && i == width / 2) bus.trigger = 1'b1;
        else bus.trigger = 1'b0;
        @(negedge clock);
      end
      bus.trigger = 1'b0;
      bus.sEcho   = 1'b0;
    end
    for (int i = 0; i < 2 * TIMEOUT && rdy_cnt == 0; i++)
      @(negedge clock);
    chk({tag, "_ready_seen"}, (rdy_cnt > 0) ? 1 : 0, 1);
    repeat (8) @(negedge clock);
    chk({tag, "_trig_clks"}, trig_hi, 2);
    chk({tag, "_ready_pulses"}, rdy_cnt, 1);
    chk({tag, "_meas"}, last_meas, exp, tol);
    chk({tag, "_meas_hold"}, int'(bus.meas), last_meas);
  endtask

  initial begin
    int w;
    int d;
    bus.trigger   = 1'b0;
    bus.triggerEn = 1'b0;
    bus.sEcho     = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_meas", int'(bus.meas), 0);
    chk("rst_ready", int'(bus.measReady), 0);
    chk("rst_strig", int'(bus.sTrigger), 0);
    @(negedge clock);
    reset = 1'b0;

    run_meas("m700", 10, 700, 1, 1'b0);
    run_meas("m300", 10, 300, 1, 1'b0);

    clr_mon();
    pulse_trigger(1'b0);
    bus.triggerEn = 1'b0;
    repeat (40) @(negedge clock);
    chk("dis_trig_clks", trig_hi, 0);
    chk("dis_ready", rdy_cnt, 0);
    chk("dis_meas_hold", int'(bus.meas), 50, 1);

    run_meas("noecho", 0, 0, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(1, 1700);
      d = $urandom_range(5, 60);
      run_meas($sformatf("rnd%0d", k), d, w, 1, k[0]);
    end
    run_meas("short", 5, 3, 1, 1'b0);
    run_meas("m2000", 8, 2000, 0, 1'b0);

    clr_mon();
    pulse_trigger(1'b1);
    repeat (6) @(negedge clock);
    bus.sEcho = 1'b1;
    repeat (300) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_meas", int'(bus.meas), 0);
    chk("mid_rst_ready", int'(bus.measReady), 0);
    chk("mid_rst_strig", int'(bus.sTrigger), 0);
    @(negedge clock);
    reset     = 1'b0;
    bus.sEcho = 1'b0;
    repeat (20) @(negedge clock);
    chk("post_rst_ready", rdy_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
